// File: rtl/auto_baud_detector.sv
// Auto-baud detector: measures the first low pulse (start bit of a 0x55 sync
// character) on a synchronized rx line and classifies it into one of four
// standard rates. The result uses the baud rate generator's baud_select encoding.
module auto_baud_detector #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       enable,
    output logic [1:0] baud_select,
    output logic       locked,
    output logic       detect_err,
    output logic       busy
);

    // Inclusive pulse-length windows in sys_clk cycles (50 MHz clock)
    localparam logic [CNT_W-1:0] WIN_2400_LO  = CNT_W'(18750);
    localparam logic [CNT_W-1:0] WIN_2400_HI  = CNT_W'(22916);
    localparam logic [CNT_W-1:0] WIN_4800_LO  = CNT_W'(9375);
    localparam logic [CNT_W-1:0] WIN_4800_HI  = CNT_W'(11459);
    localparam logic [CNT_W-1:0] WIN_9600_LO  = CNT_W'(4687);
    localparam logic [CNT_W-1:0] WIN_9600_HI  = CNT_W'(5729);
    localparam logic [CNT_W-1:0] WIN_19200_LO = CNT_W'(2344);
    localparam logic [CNT_W-1:0] WIN_19200_HI = CNT_W'(2864);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_LOCKED  = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic                   win_hit;
    logic [1:0]             win_sel;

    // rx synchronizer; flops preset to the idle-high level
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Classify the held pulse length against the rate windows
    always_comb begin
        win_hit = 1'b0;
        win_sel = 2'b00;
        if (cnt >= WIN_2400_LO && cnt <= WIN_2400_HI) begin
            win_hit = 1'b1;
            win_sel = 2'b00;
        end else if (cnt >= WIN_4800_LO && cnt <= WIN_4800_HI) begin
            win_hit = 1'b1;
            win_sel = 2'b01;
        end else if (cnt >= WIN_9600_LO && cnt <= WIN_9600_HI) begin
            win_hit = 1'b1;
            win_sel = 2'b10;
        end else if (cnt >= WIN_19200_LO && cnt <= WIN_19200_HI) begin
            win_hit = 1'b1;
            win_sel = 2'b11;
        end
    end

    // Detector FSM with pulse counter; enable=0 overrides every transition
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            baud_select <= 2'b00;
            locked      <= 1'b0;
            detect_err  <= 1'b0;
        end else begin
            detect_err <= 1'b0;
            if (!enable) begin
                // Drop any measurement silently; keep the last detected rate
                state  <= S_IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_s) state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (!rx_s) begin
                            cnt   <= CNT_W'(1);
                            state <= S_MEASURE;
                        end
                    end
                    S_MEASURE: begin
                        if (!rx_s) begin
                            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                        end else begin
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (win_hit) begin
                            baud_select <= win_sel;
                            locked      <= 1'b1;
                            state       <= S_LOCKED;
                        end else begin
                            detect_err <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                    S_LOCKED: begin
                        // Rate is held until enable drops or reset
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state == S_MEASURE) || (state == S_CHECK);

endmodule

// File: tb/tb_auto_baud_detector.sv
// Directed testbench for auto_baud_detector: rate detection, latency,
// window edges, counter saturation, enable abort, locked hold and reset.
`timescale 1ns/1ps
module tb_auto_baud_detector;

    logic       sys_clk;
    logic       reset;
    logic       rx;
    logic       enable;
    logic [1:0] baud_select;
    logic       locked;
    logic       detect_err;
    logic       busy;

    // Narrow-counter instance so saturation is reachable in a short run
    logic       rx2;
    logic       enable2;
    logic [1:0] baud_select2;
    logic       locked2;
    logic       detect_err2;
    logic       busy2;

    int compared   = 0;
    int mismatched = 0;
    int err_seen   = 0;
    int err2_seen  = 0;
    int e0;

    auto_baud_detector #(.CNT_W(16), .SYNC_STAGES(2)) u_dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .rx          (rx),
        .enable      (enable),
        .baud_select (baud_select),
        .locked      (locked),
        .detect_err  (detect_err),
        .busy        (busy)
    );

    auto_baud_detector #(.CNT_W(12), .SYNC_STAGES(2)) u_sat (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .rx          (rx2),
        .enable      (enable2),
        .baud_select (baud_select2),
        .locked      (locked2),
        .detect_err  (detect_err2),
        .busy        (busy2)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    // Count detect_err high cycles, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (detect_err === 1'b1) err_seen++;
        if (detect_err2 === 1'b1) err2_seen++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Drive rx low for n rising edges, then return it high (starts/ends at negedge)
    task automatic low_pulse(input int n);
        rx = 1'b0;
        repeat (n) @(negedge sys_clk);
        rx = 1'b1;
    endtask

    // Send the detector back through IDLE and re-arm on an idle-high line
    task automatic rearm();
        enable = 1'b0;
        @(negedge sys_clk);
        enable = 1'b1;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; rx = 1'b1; enable2 = 1'b0; rx2 = 1'b1;
        repeat (3) @(negedge sys_clk);
        compared++;
        if (baud_select !== 2'b00) begin mismatched++; $display("FAIL reset_baud: got %b want 00", baud_select); end
        compared++;
        if (locked !== 1'b0) begin mismatched++; $display("FAIL reset_locked: got %b want 0", locked); end
        compared++;
        if (detect_err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", detect_err); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_9600_latency();
        enable = 1'b1;
        repeat (100) @(negedge sys_clk);
        e0 = err_seen;
        low_pulse(5208);
        repeat (3) @(negedge sys_clk);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL lat_busy_e3: got %b want 1", busy); end
        compared++;
        if (locked !== 1'b0) begin mismatched++; $display("FAIL lat_locked_e3: got %b want 0", locked); end
        @(negedge sys_clk);
        compared++;
        if (locked !== 1'b1) begin mismatched++; $display("FAIL lat_locked_e4: got %b want 1", locked); end
        compared++;
        if (baud_select !== 2'b10) begin mismatched++; $display("FAIL lat_baud: got %b want 10", baud_select); end
        repeat (3) @(negedge sys_clk);
        compared++;
        if (err_seen - e0 !== 0) begin mismatched++; $display("FAIL lat_err: got %0d pulses want 0", err_seen - e0); end
    endtask

    task automatic test_rates();
        int         lens [3] = '{20833, 10417, 2604};
        logic [1:0] sels [3] = '{2'b00, 2'b01, 2'b11};
        for (int k = 0; k < 3; k++) begin
            enable = 1'b0;
            @(negedge sys_clk);
            compared++;
            if (locked !== 1'b0) begin mismatched++; $display("FAIL rate%0d_unlock: got %b want 0", k, locked); end
            enable = 1'b1;
            repeat (5) @(negedge sys_clk);
            low_pulse(lens[k]);
            repeat (4) @(negedge sys_clk);
            compared++;
            if (baud_select !== sels[k]) begin mismatched++; $display("FAIL rate%0d_baud: got %b want %b", k, baud_select, sels[k]); end
            compared++;
            if (locked !== 1'b1) begin mismatched++; $display("FAIL rate%0d_locked: got %b want 1", k, locked); end
        end
    endtask

    task automatic test_window_edges();
        rearm();
        e0 = err_seen;
        low_pulse(2343);
        repeat (6) @(negedge sys_clk);
        compared++;
        if (err_seen - e0 !== 1) begin mismatched++; $display("FAIL win2343_err: got %0d pulses want 1", err_seen - e0); end
        compared++;
        if (locked !== 1'b0) begin mismatched++; $display("FAIL win2343_locked: got %b want 0", locked); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL win2343_busy: got %b want 0", busy); end
        compared++;
        if (baud_select !== 2'b11) begin mismatched++; $display("FAIL win2343_baud: got %b want 11", baud_select); end
        // Erroring returns to IDLE, which re-arms on its own with enable high
        low_pulse(2344);
        repeat (4) @(negedge sys_clk);
        compared++;
        if (locked !== 1'b1) begin mismatched++; $display("FAIL win2344_locked: got %b want 1", locked); end
        compared++;
        if (baud_select !== 2'b11) begin mismatched++; $display("FAIL win2344_baud: got %b want 11", baud_select); end
    endtask

    task automatic test_saturation();
        enable2 = 1'b1;
        repeat (5) @(negedge sys_clk);
        e0 = err2_seen;
        rx2 = 1'b0;
        repeat (5000) @(negedge sys_clk);
        rx2 = 1'b1;
        repeat (6) @(negedge sys_clk);
        compared++;
        if (err2_seen - e0 !== 1) begin mismatched++; $display("FAIL sat_err: got %0d pulses want 1", err2_seen - e0); end
        compared++;
        if (locked2 !== 1'b0) begin mismatched++; $display("FAIL sat_locked: got %b want 0", locked2); end
        compared++;
        if (baud_select2 !== 2'b00) begin mismatched++; $display("FAIL sat_baud: got %b want 00", baud_select2); end
        enable2 = 1'b0;
    endtask

    task automatic test_enable_abort();
        rearm();
        e0 = err_seen;
        rx = 1'b0;
        repeat (3000) @(negedge sys_clk);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL abort_busy_mid: got %b want 1", busy); end
        enable = 1'b0;
        @(negedge sys_clk);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy_idle: got %b want 0", busy); end
        compared++;
        if (locked !== 1'b0) begin mismatched++; $display("FAIL abort_locked: got %b want 0", locked); end
        repeat (2207) @(negedge sys_clk);
        rx = 1'b1;
        repeat (10) @(negedge sys_clk);
        compared++;
        if (err_seen - e0 !== 0) begin mismatched++; $display("FAIL abort_err: got %0d pulses want 0", err_seen - e0); end
        compared++;
        if (baud_select !== 2'b11) begin mismatched++; $display("FAIL abort_baud_kept: got %b want 11", baud_select); end
        enable = 1'b1;
        repeat (5) @(negedge sys_clk);
        low_pulse(5208);
        repeat (4) @(negedge sys_clk);
        compared++;
        if (locked !== 1'b1) begin mismatched++; $display("FAIL abort_relock: got %b want 1", locked); end
        compared++;
        if (baud_select !== 2'b10) begin mismatched++; $display("FAIL abort_rebaud: got %b want 10", baud_select); end
    endtask

    task automatic test_locked_hold();
        e0 = err_seen;
        for (int k = 0; k < 2; k++) begin
            repeat (20) @(negedge sys_clk);
            low_pulse(2604);
            repeat (6) @(negedge sys_clk);
        end
        compared++;
        if (baud_select !== 2'b10) begin mismatched++; $display("FAIL hold_baud: got %b want 10", baud_select); end
        compared++;
        if (locked !== 1'b1) begin mismatched++; $display("FAIL hold_locked: got %b want 1", locked); end
        compared++;
        if (err_seen - e0 !== 0) begin mismatched++; $display("FAIL hold_err: got %0d pulses want 0", err_seen - e0); end
        reset = 1'b1;
        @(negedge sys_clk);
        compared++;
        if (baud_select !== 2'b00) begin mismatched++; $display("FAIL hold_reset_baud: got %b want 00", baud_select); end
        compared++;
        if (locked !== 1'b0) begin mismatched++; $display("FAIL hold_reset_locked: got %b want 0", locked); end
        reset = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset_mid_measure();
        enable = 1'b1;
        repeat (5) @(negedge sys_clk);
        e0 = err_seen;
        rx = 1'b0;
        repeat (1000) @(negedge sys_clk);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge sys_clk);
        rx = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        repeat (6) @(negedge sys_clk);
        compared++;
        if (err_seen - e0 !== 0) begin mismatched++; $display("FAIL rstmid_err: got %0d pulses want 0", err_seen - e0); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        compared++;
        if (locked !== 1'b0) begin mismatched++; $display("FAIL rstmid_locked: got %b want 0", locked); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rx = 1'b1; enable2 = 1'b0; rx2 = 1'b1;
        @(negedge sys_clk);
        test_reset();
        test_9600_latency();
        test_rates();
        test_window_edges();
        test_saturation();
        test_enable_abort();
        test_locked_hold();
        test_reset_mid_measure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/auto_baud_detector.md
AUTO_BAUD_DETECTOR -- requirements
Module: auto_baud_detector

Interface
REQ-001 Parameter: CNT_W, default 16, width of the pulse-length counter in sys_clk cycles.
REQ-002 Parameter: SYNC_STAGES, default 2, number of flip-flops in the rx input synchronizer.
REQ-003 sys_clk  input  1  system clock, 50 MHz; all logic on the rising edge; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 enable  input  1  high: detector armed; low: detector returns to IDLE and clears locked.
REQ-007 baud_select  output  2  detected rate: 00=2400, 01=4800, 10=9600, 11=19200; same encoding as the baud rate generator's baud_select input.
REQ-008 locked  output  1  high while a valid rate has been detected and enable is high.
REQ-009 detect_err  output  1  one-cycle pulse when a measured pulse falls outside every rate window.
REQ-010 busy  output  1  high in MEASURE and CHECK states.

Function
REQ-011 rx shall pass through a SYNC_STAGES-deep synchronizer; its output is rx_s; the block shall not use rx directly anywhere else.
REQ-012 FSM states: IDLE, ARMED, MEASURE, CHECK, LOCKED.
REQ-013 IDLE: when enable=1 and rx_s=1, go to ARMED; otherwise stay. This guarantees an idle-high line before any measurement.
REQ-014 ARMED: when rx_s=0, load cnt=1 and go to MEASURE.
REQ-015 MEASURE: when rx_s=0, increment cnt, saturating at 2^CNT_W-1; when rx_s=1, go to CHECK holding cnt.
REQ-016 cnt shall equal the number of rising edges at which rx_s was sampled low.
REQ-017 CHECK (one cycle only) shall classify cnt inclusively:
- 18750..22916 gives 00.
- 9375..11459 gives 01.
- 4687..5729 gives 10.
- 2344..2864 gives 11.
REQ-018 CHECK with a match: register baud_select, set locked=1, and go to LOCKED.
REQ-019 CHECK with no match, including saturation and short glitches: pulse detect_err for exactly one cycle, leave baud_select and locked unchanged, and go to IDLE.
REQ-020 LOCKED: hold baud_select and locked; ignore further rx activity.
REQ-021 In every state, enable=0 shall force IDLE on the next edge:
- locked clears on that edge.
- baud_select retains its last value.
- An in-progress measurement is discarded with no detect_err.
REQ-022 Priority when events coincide: reset > enable=0 > state transition.
REQ-023 Latency: baud_select and locked update at the 4th sys_clk rising edge after the first edge that samples pin rx high at the end of the pulse (SYNC_STAGES=2).
REQ-024 The intended sync character is 0x55: its start bit is the first low pulse and lasts one bit period. Only the first low pulse after ARMED shall be measured.
REQ-025 Arithmetic shall be unsigned, with comparisons at full CNT_W width; the window constants shall be localparams.

Reset
REQ-026 On reset=1 at a sys_clk edge:
- state=IDLE, cnt=0.
- Synchronizer flops = 1.
- baud_select=00, locked=0, detect_err=0, busy=0.
REQ-027 Reset asserted mid-MEASURE shall abort the measurement with no detect_err pulse.
REQ-028 No output shall change between edges; there is no asynchronous path from reset or rx to any output.

Verification
REQ-029 Reset, enable=1, rx high 100 cycles, rx low 5208 cycles, then high -> baud_select=10 and locked=1 exactly 4 edges after the rise; detect_err stays 0.
REQ-030 Low pulses of 20833, 10417 and 2604 cycles, each preceded by enable toggled 0->1 -> baud_select = 00, 01, 11 respectively, locked=1 each time.
REQ-031 Window edges: low 2343 cycles -> single detect_err pulse, state IDLE, locked=0; low 2344 -> baud_select=11, locked=1.
REQ-032 rx held low beyond 65535 cycles, then released -> cnt saturates at 65535, one detect_err pulse, baud_select unchanged.
REQ-033 enable dropped to 0 at cycle 3000 of a 5208-cycle low pulse -> IDLE next edge, no detect_err, locked=0; re-enable with rx high then a 5208 pulse -> locked=1, baud_select=10.
REQ-034 While LOCKED at 10, apply low pulses of 2604 cycles -> baud_select stays 10; reset asserted -> baud_select=00, locked=0 on the next edge.
